// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax row-max/subtract front stage.
// Element width and lane count are fixed here; row depth is a top-level parameter.
package softmax_pkg;

    localparam int LANES         = 8;
    localparam int DATA_W        = 8;
    localparam int DIFF_W        = DATA_W + 1;
    localparam int DEF_ROW_BEATS = 8;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic signed [DIFF_W-1:0] diff_t;

    typedef enum logic {
        S_FILL,
        S_DRAIN
    } state_t;

    localparam elem_t ELEM_MIN = elem_t'(1 << (DATA_W - 1));

    function automatic elem_t max_elem(input elem_t a, input elem_t b);
        return (a > b) ? a : b;
    endfunction

    // Both operands are sign-extended first, so the result never wraps.
    function automatic diff_t elem_diff(input elem_t x, input elem_t m);
        return diff_t'(x) - diff_t'(m);
    endfunction

endpackage

// File: rtl/softmax_row_max_sub_max_tree8.sv
// Combinational signed maximum of eight packed elements, built as a
// three-level pairwise compare tree.
module max_tree8
    import softmax_pkg::*;
(
    input  logic [8*DATA_W-1:0] data,
    output elem_t               max_val
);

    elem_t l0 [8];
    elem_t l1 [4];
    elem_t l2 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            l0[i] = elem_t'(data[i*DATA_W +: DATA_W]);
        end
        for (int i = 0; i < 4; i++) begin
            l1[i] = max_elem(l0[2*i], l0[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            l2[i] = max_elem(l1[2*i], l1[2*i+1]);
        end
        max_val = max_elem(l2[0], l2[1]);
    end

endmodule

// File: rtl/softmax_row_max_sub.sv
// Buffers one row of int8 beats while tracking its maximum, then replays
// the row as (x - row_max) for the exp lookup stage.
module softmax_row_max_sub
    import softmax_pkg::*;
#(
    parameter int ROW_BEATS = DEF_ROW_BEATS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DIFF_W-1:0]  out_data,
    output logic                     out_last,
    output logic [DATA_W-1:0]        row_max,
    output logic                     err_len
);

    localparam int              CNT_W    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_BEATS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        wr_cnt, rd_cnt, last_idx_q;
    elem_t                   run_max, tree_max, fill_max;
    logic [LANES*DATA_W-1:0] row_buf [ROW_BEATS];
    logic [LANES*DATA_W-1:0] rd_word;
    logic                    in_fire, out_fire, fill_close;

    max_tree8 u_max_tree (
        .data    (in_data),
        .max_val (tree_max)
    );

    assign in_ready   = (state_q == S_FILL) && rst_n;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = (state_q == S_DRAIN);
    assign out_fire   = out_valid && out_ready;
    assign out_last   = out_valid && (rd_cnt == last_idx_q);
    assign fill_close = in_fire && (in_last || wr_cnt == LAST_IDX);
    // The first beat of a row must not inherit the previous row's maximum.
    assign fill_max   = (wr_cnt == '0) ? tree_max : max_elem(run_max, tree_max);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_close)           state_d = S_DRAIN;
            S_DRAIN: if (out_fire && out_last) state_d = S_FILL;
            default:                           state_d = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            last_idx_q <= '0;
            run_max    <= ELEM_MIN;
            row_max    <= ELEM_MIN;
            err_len    <= 1'b0;
        end else begin
            err_len <= in_fire && !in_last && (wr_cnt == LAST_IDX);
            if (in_fire) begin
                run_max <= fill_max;
                wr_cnt  <= wr_cnt + 1'b1;
                if (fill_close) begin
                    last_idx_q <= wr_cnt;
                    row_max    <= fill_max;
                end
            end
            if (out_fire) begin
                if (out_last) begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: the row buffer has no reset; every entry is written in FILL before DRAIN can read it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            row_buf[wr_cnt] <= in_data;
        end
    end

    assign rd_word = row_buf[rd_cnt];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int i = 0; i < LANES; i++) begin
                out_data[i*DIFF_W +: DIFF_W] =
                    elem_diff(elem_t'(rd_word[i*DATA_W +: DATA_W]), elem_t'(row_max));
            end
        end
    end

endmodule

// File: tb/tb_softmax_row_max_sub.sv
// Self-checking bench: directed rows with literal expectations plus random rows
// compared every cycle against a row-level max/subtract model.
module tb_softmax_row_max_sub;
    import softmax_pkg::*;

    localparam int RB = DEF_ROW_BEATS;
    localparam int IW = LANES * DATA_W;
    localparam int OW = LANES * DIFF_W;
    localparam int RDY_ALWAYS = 0;
    localparam int RDY_RANDOM = 1;
    localparam int RDY_MANUAL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [DATA_W-1:0] row_max;
    logic          err_len;

    softmax_row_max_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .row_max   (row_max),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Row-level reference model
    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [IW-1:0] cur_row[$];
    logic [DATA_W-1:0] exp_max = 8'h80;
    bit            err_exp = 1'b0;
    bit            post_rst = 1'b1;
    bit            check_en = 1'b0;
    int            rdy_mode = RDY_MANUAL;

    function automatic void accept(input logic [IW-1:0] d, input logic last);
        int    m;
        int    x;
        beat_t b;
        cur_row.push_back(d);
        if (last || cur_row.size() == RB) begin
            m = -128;
            foreach (cur_row[k]) begin
                for (int l = 0; l < LANES; l++) begin
                    x = int'($signed(cur_row[k][l*DATA_W +: DATA_W]));
                    if (x > m) m = x;
                end
            end
            foreach (cur_row[k]) begin
                b.data = '0;
                for (int l = 0; l < LANES; l++) begin
                    x = int'($signed(cur_row[k][l*DATA_W +: DATA_W]));
                    b.data[l*DIFF_W +: DIFF_W] = DIFF_W'(x - m);
                end
                b.last = (k == cur_row.size() - 1);
                exp_q.push_back(b);
            end
            exp_max = DATA_W'(m);
            err_exp = !last;
            cur_row.delete();
        end
    endfunction

    // Compare process: check this cycle, then advance the model over the coming edge.
    always @(negedge clk) begin
        bit busy;
        if (check_en) begin
            busy = (exp_q.size() > 0);
            check("out_valid", out_valid, busy);
            check("in_ready", in_ready, rst_n && !busy);
            check("err_len", err_len, err_exp);
            if (busy) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_last", out_last, exp_q[0].last);
                check("row_max", row_max, exp_max);
            end
            if (post_rst) begin
                check("rst_out_data", out_data, 0);
                check("rst_row_max", row_max, 8'h80);
                check("rst_out_last", out_last, 0);
            end
            err_exp  = 1'b0;
            post_rst = 1'b0;
            if (!rst_n) begin
                exp_q.delete();
                cur_row.delete();
                exp_max  = 8'h80;
                post_rst = 1'b1;
            end else if (busy) begin
                if (out_ready) void'(exp_q.pop_front());
            end else if (in_valid) begin
                accept(in_data, in_last);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                RDY_ALWAYS: out_ready = 1'b1;
                RDY_RANDOM: out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    function automatic logic [IW-1:0] pack8(input int v [LANES]);
        logic [IW-1:0] p;
        for (int l = 0; l < LANES; l++) p[l*DATA_W +: DATA_W] = DATA_W'(v[l]);
        return p;
    endfunction

    function automatic logic [OW-1:0] pack9(input int v [LANES]);
        logic [OW-1:0] p;
        for (int l = 0; l < LANES; l++) p[l*DIFF_W +: DIFF_W] = DIFF_W'(v[l]);
        return p;
    endfunction

    function automatic int rand_elem();
        case ($urandom_range(0, 7))
            0:       return -128;
            1:       return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    // Called and returns at posedge+1; holds the beat until accepted or timed out.
    task automatic send_beat(input logic [IW-1:0] d, input logic last);
        bit acc;
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 300);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit idle;
        int waited;
        rdy_mode = RDY_ALWAYS;
        waited   = 0;
        idle     = 1'b0;
        while (!idle && waited < 300) begin
            @(negedge clk);
            idle = in_ready;
            waited++;
        end
        if (!idle) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic manual_step();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] od;
        int            v [LANES];
        int            len;
        bit            ovf;

        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-beat row, max 20
        rdy_mode = RDY_MANUAL;
        out_ready = 1'b0;
        send_beat(pack8('{1, 2, 3, 4, 5, 6, 7, 8}), 1'b0);
        send_beat(pack8('{-3, 20, 0, 5, 5, 5, 5, 5}), 1'b1);
        @(negedge clk);
        check("t1_beat0", out_data, pack9('{-19, -18, -17, -16, -15, -14, -13, -12}));
        check("t1_max", row_max, 8'd20);
        check("t1_last0", out_last, 1'b0);
        manual_step();
        @(negedge clk);
        check("t1_beat1", out_data, pack9('{-23, 0, -20, -15, -15, -15, -15, -15}));
        check("t1_last1", out_last, 1'b1);
        drain();

        // Single beat of all -128
        rdy_mode = RDY_MANUAL;
        out_ready = 1'b0;
        send_beat(pack8('{-128, -128, -128, -128, -128, -128, -128, -128}), 1'b1);
        @(negedge clk);
        check("t2_valid", out_valid, 1'b1);
        check("t2_data", out_data, 0);
        check("t2_max", row_max, 8'h80);
        check("t2_last", out_last, 1'b1);
        drain();

        // Widest difference
        rdy_mode = RDY_MANUAL;
        out_ready = 1'b0;
        send_beat(pack8('{127, -128, 0, 0, 0, 0, 0, 0}), 1'b1);
        @(negedge clk);
        od = out_data;
        check("t3_lane0", od[0 +: DIFF_W], 9'h000);
        check("t3_lane1", od[DIFF_W +: DIFF_W], 9'h101);
        check("t3_lane2", od[2*DIFF_W +: DIFF_W], 9'h181);
        drain();

        // Overflowing row without in_last
        rdy_mode = RDY_MANUAL;
        out_ready = 1'b0;
        for (int b = 0; b < RB; b++) begin
            for (int l = 0; l < LANES; l++) v[l] = b * 10 - l;
            send_beat(pack8(v), 1'b0);
        end
        @(negedge clk);
        check("t4_err_len", err_len, 1'b1);
        check("t4_max", row_max, 8'd70);
        drain();

        // Random rows with random backpressure
        rdy_mode = RDY_RANDOM;
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, RB);
            ovf = (len == RB) && ($urandom_range(0, 2) == 0);
            for (int b = 0; b < len; b++) begin
                for (int l = 0; l < LANES; l++) v[l] = rand_elem();
                send_beat(pack8(v), !ovf && (b == len - 1));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        // Reset mid-DRAIN, then a fresh row with a smaller maximum
        rdy_mode = RDY_MANUAL;
        out_ready = 1'b0;
        send_beat(pack8('{100, 1, 2, 3, 4, 5, 6, 7}), 1'b0);
        send_beat(pack8('{9, 8, 7, 6, 5, 4, 3, 2}), 1'b1);
        manual_step();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_valid_after_rst", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send_beat(pack8('{-100, -50, -90, -128, -60, -70, -80, -51}), 1'b1);
        @(negedge clk);
        check("t6_max", row_max, 8'hCE);
        check("t6_data", out_data, pack9('{-50, 0, -40, -78, -10, -20, -30, -1}));
        check("t6_last", out_last, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
